// File: rtl/lfo_multiwave.sv
// rtl/lfo_multiwave.sv - multi-channel phase-accumulator LFO with four waveforms and depth scaling
module lfo_multiwave #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 9,
  parameter int N_CH    = 2,
  parameter int DEPTH_W = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  sample_tick_i,
  input  logic [PHASE_W-1:0]    phase_incr_i,
  input  logic [PHASE_W-1:0]    offset_i,
  input  logic [1:0]            wave_sel_i,
  input  logic [DEPTH_W-1:0]    depth_i,
  input  logic                  retrig_i,
  output logic [N_CH*OUT_W-1:0] modulator_o,
  output logic                  valid_o
);
  localparam logic [OUT_W-1:0] MAX = '1;
  localparam int SHP_W = 2*OUT_W + 1;
  localparam int DP_W  = OUT_W + DEPTH_W;

  logic [PHASE_W-1:0]         r_acc;
  logic [PHASE_W-1:0]         r_offset;
  logic [1:0]                 r_wave;
  logic [DEPTH_W-1:0]         r_depth1;
  logic [DEPTH_W-1:0]         r_depth2;
  logic                       r_pend;
  logic                       r_v1;
  logic                       r_v2;
  logic                       r_valid;
  logic [N_CH-1:0][OUT_W-1:0] r_shape;
  logic [N_CH-1:0][OUT_W-1:0] r_mod;

  logic [PHASE_W:0]           w_sum;
  logic                       w_apply;
  logic [N_CH-1:0][OUT_W-1:0] w_shape;

  assign w_sum   = {1'b0, r_acc} + {1'b0, phase_incr_i};
  assign w_apply = sample_tick_i & (r_pend | retrig_i);

  // Waveform only switches at a period boundary (wrap or restart) so the output never jumps mid-cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_acc    <= '0;
      r_offset <= '0;
      r_wave   <= 2'd0;
      r_depth1 <= '0;
      r_pend   <= 1'b0;
      r_v1     <= 1'b0;
    end else begin
      r_v1 <= sample_tick_i;
      if (sample_tick_i) begin
        r_acc    <= w_apply ? '0 : w_sum[PHASE_W-1:0];
        r_offset <= offset_i;
        r_depth1 <= depth_i;
        r_pend   <= 1'b0;
        if (w_apply || w_sum[PHASE_W]) r_wave <= wave_sel_i;
      end else if (retrig_i) begin
        r_pend <= 1'b1;
      end
    end
  end

  function automatic logic [OUT_W-1:0] shape(input logic [1:0] sel, input logic [PHASE_W-1:0] phase);
    logic [OUT_W-1:0] v_u;
    logic [OUT_W-1:0] v_ramp;
    logic [OUT_W-1:0] v_tri;
    logic [OUT_W:0]   v_inv;
    logic [SHP_W-1:0] v_prod;
    logic [OUT_W-1:0] v_res;
    v_u    = OUT_W'(phase >> (PHASE_W - OUT_W));
    v_ramp = {v_u[OUT_W-2:0], 1'b0};
    v_tri  = v_u[OUT_W-1] ? ~v_ramp : v_ramp;
    // 2^(OUT_W+1)-1-T is simply T inverted with a leading one.
    v_inv  = {1'b1, ~v_tri};
    v_prod = SHP_W'(v_tri) * SHP_W'(v_inv);
    case (sel)
      2'd0:    v_res = v_tri;
      2'd1:    v_res = v_u[OUT_W-1] ? '0 : MAX;
      2'd2:    v_res = ~v_u;
      default: v_res = OUT_W'(v_prod >> OUT_W);
    endcase
    return v_res;
  endfunction

  function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0] w, input logic [DEPTH_W-1:0] d);
    logic [DP_W-1:0]  v_prod;
    logic [OUT_W-1:0] v_res;
    v_prod = DP_W'(MAX - w) * DP_W'(d);
    v_res  = (&d) ? w : MAX - OUT_W'(v_prod >> DEPTH_W);
    return v_res;
  endfunction

  always_comb begin
    logic [PHASE_W-1:0] v_phase;
    v_phase = r_acc;
    w_shape = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_shape[k] = shape(r_wave, v_phase);
      v_phase    = v_phase + r_offset;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_shape  <= '0;
      r_depth2 <= '0;
      r_v2     <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_shape  <= w_shape;
        r_depth2 <= r_depth1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_mod   <= {N_CH{MAX}};
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v2;
      if (r_v2) begin
        for (int k = 0; k < N_CH; k++) r_mod[k] <= scale(r_shape[k], r_depth2);
      end
    end
  end

  assign modulator_o = r_mod;
  assign valid_o     = r_valid;

endmodule

// File: tb/tb_lfo_multiwave.sv
// tb/tb_lfo_multiwave.sv - directed and random bench for lfo_multiwave against an arithmetic reference model
module tb_lfo_multiwave;
  localparam int PW   = 24;
  localparam int OW   = 9;
  localparam int NC   = 2;
  localparam int DW   = 8;
  localparam int MAXV = (1 << OW) - 1;
  localparam int HALF = 1 << (OW - 1);

  logic             clk_i = 1'b0;
  logic             arst_n_i = 1'b1;
  logic             sample_tick_i = 1'b0;
  logic [PW-1:0]    phase_incr_i = '0;
  logic [PW-1:0]    offset_i = '0;
  logic [1:0]       wave_sel_i = 2'd0;
  logic [DW-1:0]    depth_i = '1;
  logic             retrig_i = 1'b0;
  logic [NC*OW-1:0] modulator_o;
  logic             valid_o;

  lfo_multiwave #(.PHASE_W(PW), .OUT_W(OW), .N_CH(NC), .DEPTH_W(DW)) dut (
    .clk_i         (clk_i),
    .arst_n_i      (arst_n_i),
    .sample_tick_i (sample_tick_i),
    .phase_incr_i  (phase_incr_i),
    .offset_i      (offset_i),
    .wave_sel_i    (wave_sel_i),
    .depth_i       (depth_i),
    .retrig_i      (retrig_i),
    .modulator_o   (modulator_o),
    .valid_o       (valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int               due;
    logic [NC*OW-1:0] vals;
    int               spot;
  } exp_t;

  exp_t             q[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               edge_n = 0;
  longint           m_acc = 0;
  int               m_wave = 0;
  bit               m_pend = 1'b0;
  logic [NC*OW-1:0] last_out;
  logic [NC*OW-1:0] all_max;

  function automatic int wave_val(int sel, longint p);
    int u;
    int t;
    u = int'(p >> (PW - OW));
    t = (u < HALF) ? 2 * u : MAXV - 2 * (u - HALF);
    case (sel)
      0:       return t;
      1:       return (u < HALF) ? MAXV : 0;
      2:       return MAXV - u;
      default: return (t * (2 * MAXV + 1 - t)) / (MAXV + 1);
    endcase
  endfunction

  function automatic int depth_scale(int w, int d);
    if (d == (1 << DW) - 1) return w;
    return MAXV - ((MAXV - w) * d) / (1 << DW);
  endfunction

  task automatic check(string tag, logic [NC*OW-1:0] obs, logic [NC*OW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_tick(bit rt, int spot);
    longint nxt;
    bit     apply;
    bit     wrap;
    longint p;
    exp_t   e;
    nxt   = m_acc + longint'(phase_incr_i);
    apply = m_pend || rt;
    wrap  = nxt >= (longint'(1) << PW);
    m_acc = apply ? 0 : nxt % (longint'(1) << PW);
    if (apply || wrap) m_wave = int'(wave_sel_i);
    m_pend = 1'b0;
    e.due  = edge_n + 2;
    e.spot = spot;
    e.vals = '0;
    for (int k = 0; k < NC; k++) begin
      p = (m_acc + longint'(k) * longint'(offset_i)) % (longint'(1) << PW);
      e.vals[k*OW +: OW] = OW'(depth_scale(wave_val(m_wave, p), int'(depth_i)));
    end
    q.push_back(e);
  endtask

  task automatic compare();
    bit ev;
    ev = (q.size() > 0) && (q[0].due == edge_n);
    check("valid", {{(NC*OW-1){1'b0}}, valid_o}, {{(NC*OW-1){1'b0}}, ev});
    if (ev) begin
      check("out", modulator_o, q[0].vals);
      if (q[0].spot >= 0)
        check("spot_ch0", {{(NC*OW-OW){1'b0}}, modulator_o[OW-1:0]}, (NC*OW)'(q[0].spot));
      last_out = q[0].vals;
      void'(q.pop_front());
    end else begin
      check("hold", modulator_o, last_out);
    end
  endtask

  task automatic step(bit tick, bit rt, int spot);
    sample_tick_i = tick;
    retrig_i      = rt;
    @(posedge clk_i);
    edge_n++;
    if (tick) model_tick(rt, spot);
    else if (rt) m_pend = 1'b1;
    #1;
    sample_tick_i = 1'b0;
    retrig_i      = 1'b0;
    compare();
  endtask

  task automatic do_tick(int spot);
    step(1'b1, 1'b0, spot);
    repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, -1);
  endtask

  task automatic drain();
    repeat (5) step(1'b0, 1'b0, -1);
  endtask

  // Reset lands mid-cycle so its effect must be visible before any clock edge.
  task automatic do_reset();
    #2;
    arst_n_i = 1'b0;
    #1;
    check("rst_out", modulator_o, all_max);
    check("rst_valid", {{(NC*OW-1){1'b0}}, valid_o}, '0);
    q.delete();
    m_acc    = 0;
    m_wave   = 0;
    m_pend   = 1'b0;
    last_out = all_max;
    @(posedge clk_i);
    edge_n++;
    #1;
    arst_n_i = 1'b1;
    repeat (3) step(1'b0, 1'b0, -1);
  endtask

  initial begin
    all_max  = '1;
    last_out = all_max;

    do_reset();

    phase_incr_i = PW'(1 << 15);
    offset_i     = '0;
    depth_i      = '1;
    wave_sel_i   = 2'd0;
    for (int i = 1; i <= 512; i++)
      do_tick((i == 1) ? 2 : (i == 256) ? 511 : (i == 257) ? 509 : (i == 512) ? 0 : -1);
    drain();

    do_reset();
    wave_sel_i = 2'd1;
    offset_i   = PW'(1 << 23);
    step(1'b1, 1'b1, 511);
    for (int i = 1; i <= 300; i++)
      do_tick((i < 256) ? 511 : 0);
    drain();

    do_reset();
    wave_sel_i = 2'd0;
    offset_i   = '0;
    for (int i = 1; i <= 512; i++) begin
      if (i == 100) wave_sel_i = 2'd1;
      do_tick((i == 200) ? 400 : (i == 511) ? 1 : (i == 512) ? 511 : -1);
    end
    drain();

    do_reset();
    wave_sel_i = 2'd0;
    for (int i = 1; i <= 300; i++)
      do_tick((i == 300) ? 423 : -1);
    step(1'b0, 1'b1, -1);
    do_tick(0);
    do_tick(2);
    do_tick(4);
    step(1'b1, 1'b1, 0);
    do_tick(2);
    do_tick(4);
    step(1'b0, 1'b1, -1);
    step(1'b0, 1'b0, -1);
    step(1'b0, 1'b1, -1);
    do_tick(0);
    do_tick(2);
    drain();

    do_reset();
    wave_sel_i = 2'd1;
    depth_i    = DW'(128);
    step(1'b1, 1'b1, 511);
    for (int i = 1; i <= 300; i++)
      do_tick((i < 256) ? 511 : 256);
    depth_i = '0;
    for (int i = 0; i < 20; i++)
      do_tick(511);
    drain();

    do_reset();
    wave_sel_i = 2'd3;
    depth_i    = '1;
    step(1'b1, 1'b1, 0);
    for (int i = 1; i <= 256; i++)
      do_tick((i == 128) ? 383 : (i == 256) ? 511 : -1);
    drain();

    phase_incr_i = PW'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if ($urandom_range(0, 63) == 0) phase_incr_i = PW'($urandom);
      if ($urandom_range(0, 31) == 0) offset_i = PW'($urandom);
      if ($urandom_range(0, 15) == 0) wave_sel_i = 2'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0:       depth_i = '1;
          1:       depth_i = '0;
          default: depth_i = DW'($urandom);
        endcase
      end
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, -1);
    end
    drain();
    check("queue_empty", (NC*OW)'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
